// File: rtl/av_mem_arbiter_pkg.sv
// Shared types and sizing helpers for the two-master Avalon memory arbiter.
// Build option AV_MEM_ARB_FIXED_PRIO_EN is consumed by av_mem_arbiter_rr_arb2 only.
package av_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_0    = 2'd1,
    GNT_1    = 2'd2
  } gnt_e;

  localparam int AV_DATA_W = 32;

  function automatic int av_addr_w(input int asb);
    return 30 - asb;
  endfunction

endpackage

// File: rtl/av_mem_arbiter_rr_arb2.sv
// Two-requester picker: held grant wins, else round-robin on ties.
// Macro AV_MEM_ARB_FIXED_PRIO_EN: requester 0 always wins ties.
module av_mem_arbiter_rr_arb2 (
  input  logic [1:0] i_Req,
  input  logic       i_Last,
  input  logic [1:0] i_Hold,
  output logic [1:0] o_Gnt
);

`ifdef AV_MEM_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = i_Last;
`endif

  always_comb begin
    o_Gnt = 2'b00;
    if (|i_Hold) begin
      o_Gnt = i_Hold;
    end else if (&i_Req) begin
`ifdef AV_MEM_ARB_FIXED_PRIO_EN
      o_Gnt = 2'b01;
`else
      o_Gnt = i_Last ? 2'b01 : 2'b10;
`endif
    end else begin
      o_Gnt = i_Req;
    end
  end

endmodule

// File: rtl/av_mem_arbiter.sv
// Shares one 1-cycle-latency Avalon memory slave between fetch (AV0) and data (AV1).
// Build option AV_MEM_ARB_FIXED_PRIO_EN selects fixed AV0 priority (see rr_arb2).
module av_mem_arbiter
  import av_mem_arbiter_pkg::*;
#(
  parameter int ADDR_SEL_BITS = 6,
  parameter int DATA_W        = AV_DATA_W
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst_n,
  input  logic                                  i_AV0_SlaveSel,
  input  logic [av_addr_w(ADDR_SEL_BITS)-1:0]   i_AV0_RegAddr,
  input  logic                                  i_AV0_Read,
  input  logic                                  i_AV0_Write,
  input  logic [DATA_W-1:0]                     i_AV0_WriteData,
  input  logic [DATA_W/8-1:0]                   i_AV0_ByteEn,
  output logic [DATA_W-1:0]                     o_AV0_ReadData,
  output logic                                  o_AV0_WaitRequest,
  input  logic                                  i_AV1_SlaveSel,
  input  logic [av_addr_w(ADDR_SEL_BITS)-1:0]   i_AV1_RegAddr,
  input  logic                                  i_AV1_Read,
  input  logic                                  i_AV1_Write,
  input  logic [DATA_W-1:0]                     i_AV1_WriteData,
  input  logic [DATA_W/8-1:0]                   i_AV1_ByteEn,
  output logic [DATA_W-1:0]                     o_AV1_ReadData,
  output logic                                  o_AV1_WaitRequest,
  output logic                                  o_Mem_Sel,
  output logic                                  o_Mem_Read,
  output logic                                  o_Mem_Write,
  output logic [av_addr_w(ADDR_SEL_BITS)-1:0]   o_Mem_Addr,
  output logic [DATA_W-1:0]                     o_Mem_WriteData,
  output logic [DATA_W/8-1:0]                   o_Mem_ByteEn,
  input  logic [DATA_W-1:0]                     i_Mem_ReadData,
  input  logic                                  i_Mem_WaitRequest
);

  localparam int AW = av_addr_w(ADDR_SEL_BITS);
  localparam int BW = DATA_W / 8;

  gnt_e        r_Grant;
  logic        r_LastGrant;
  logic        r_RdPend;
  logic        r_RdOwner;

  logic [1:0]  w_Act;
  logic [1:0]  w_Hold;
  logic [1:0]  w_Gnt;
  logic [1:0]  w_Eff;
  logic [1:0]  w_Acc;
  logic        w_MemRead;

  assign w_Act[0] = i_AV0_SlaveSel & (i_AV0_Read | i_AV0_Write);
  assign w_Act[1] = i_AV1_SlaveSel & (i_AV1_Read | i_AV1_Write);
  assign w_Hold   = {r_Grant == GNT_1, r_Grant == GNT_0};

  av_mem_arbiter_rr_arb2 u_arb (
    .i_Req  (w_Act),
    .i_Last (r_LastGrant),
    .i_Hold (w_Hold),
    .o_Gnt  (w_Gnt)
  );

  // A held port that dropped its request gets no transfer this cycle
  assign w_Eff = w_Gnt & w_Act;
  assign w_Acc = w_Eff & {2{~i_Mem_WaitRequest}};

  assign o_AV0_WaitRequest = w_Act[0] & ~(w_Gnt[0] & ~i_Mem_WaitRequest);
  assign o_AV1_WaitRequest = w_Act[1] & ~(w_Gnt[1] & ~i_Mem_WaitRequest);

  always_comb begin
    o_Mem_Sel       = 1'b0;
    w_MemRead       = 1'b0;
    o_Mem_Write     = 1'b0;
    o_Mem_Addr      = '0;
    o_Mem_WriteData = '0;
    o_Mem_ByteEn    = '0;
    unique case (1'b1)
      w_Eff[0]: begin
        o_Mem_Sel       = 1'b1;
        w_MemRead       = i_AV0_Read & ~i_AV0_Write;
        o_Mem_Write     = i_AV0_Write;
        o_Mem_Addr      = i_AV0_RegAddr;
        o_Mem_WriteData = i_AV0_WriteData;
        o_Mem_ByteEn    = i_AV0_ByteEn;
      end
      w_Eff[1]: begin
        o_Mem_Sel       = 1'b1;
        w_MemRead       = i_AV1_Read & ~i_AV1_Write;
        o_Mem_Write     = i_AV1_Write;
        o_Mem_Addr      = i_AV1_RegAddr;
        o_Mem_WriteData = i_AV1_WriteData;
        o_Mem_ByteEn    = i_AV1_ByteEn;
      end
      default: ;
    endcase
  end

  assign o_Mem_Read = w_MemRead;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Grant     <= GNT_NONE;
      r_LastGrant <= 1'b1;
      r_RdPend    <= 1'b0;
      r_RdOwner   <= 1'b0;
    end else begin
      r_RdPend <= (|w_Acc) & w_MemRead;
      if (|w_Acc) begin
        r_RdOwner   <= w_Acc[1];
        r_LastGrant <= w_Acc[1];
      end
      unique case (1'b1)
        w_Eff[0] & i_Mem_WaitRequest: r_Grant <= GNT_0;
        w_Eff[1] & i_Mem_WaitRequest: r_Grant <= GNT_1;
        default:                      r_Grant <= GNT_NONE;
      endcase
    end
  end

  assign o_AV0_ReadData = (r_RdPend & ~r_RdOwner) ? i_Mem_ReadData : '0;
  assign o_AV1_ReadData = (r_RdPend &  r_RdOwner) ? i_Mem_ReadData : '0;

  logic [AW+BW-1:0] w_unused_w;
  assign w_unused_w = '0;

endmodule

// File: tb/tb_av_mem_arbiter.sv
// Self-checking bench for av_mem_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_av_mem_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk;
  logic          rst_n;
  logic          sel  [2];
  logic          rd   [2];
  logic          wr   [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wd   [2];
  logic [BW-1:0] be   [2];
  logic [DW-1:0] rdata0, rdata1;
  logic          wait0, wait1;
  logic          m_sel, m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [BW-1:0] m_be;
  logic [DW-1:0] mem_rd;
  logic          mem_wait;

  av_mem_arbiter dut (
    .i_Clk             (clk),
    .i_Rst_n           (rst_n),
    .i_AV0_SlaveSel    (sel[0]),
    .i_AV0_RegAddr     (addr[0]),
    .i_AV0_Read        (rd[0]),
    .i_AV0_Write       (wr[0]),
    .i_AV0_WriteData   (wd[0]),
    .i_AV0_ByteEn      (be[0]),
    .o_AV0_ReadData    (rdata0),
    .o_AV0_WaitRequest (wait0),
    .i_AV1_SlaveSel    (sel[1]),
    .i_AV1_RegAddr     (addr[1]),
    .i_AV1_Read        (rd[1]),
    .i_AV1_Write       (wr[1]),
    .i_AV1_WriteData   (wd[1]),
    .i_AV1_ByteEn      (be[1]),
    .o_AV1_ReadData    (rdata1),
    .o_AV1_WaitRequest (wait1),
    .o_Mem_Sel         (m_sel),
    .o_Mem_Read        (m_rd),
    .o_Mem_Write       (m_wr),
    .o_Mem_Addr        (m_addr),
    .o_Mem_WriteData   (m_wd),
    .o_Mem_ByteEn      (m_be),
    .i_Mem_ReadData    (mem_rd),
    .i_Mem_WaitRequest (mem_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: which port holds a stalled grant, who won last, pending read owner
  int      mdl_hold  = -1;
  int      mdl_last  = 1;
  bit      mdl_pend  = 1'b0;
  int      mdl_owner = 0;
  bit      e_wait [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    int g;
    bit act [2];
    bit eff, acc;
    logic [DW-1:0] er [2];
    if (!rst_n) begin
      mdl_hold = -1; mdl_last = 1; mdl_pend = 1'b0; mdl_owner = 0;
      e_wait[0] = 1'b0; e_wait[1] = 1'b0;
    end else if (chk_en) begin
      for (int x = 0; x < 2; x++) act[x] = sel[x] && (rd[x] || wr[x]);
      g = -1;
      if (mdl_hold >= 0) g = mdl_hold;
      else if (act[0] && act[1]) begin
`ifdef AV_MEM_ARB_FIXED_PRIO_EN
        g = 0;
`else
        g = (mdl_last == 0) ? 1 : 0;
`endif
      end
      else if (act[0]) g = 0;
      else if (act[1]) g = 1;
      eff = (g >= 0) && act[g];
      acc = eff && !mem_wait;
      for (int x = 0; x < 2; x++) begin
        e_wait[x] = act[x] && !(g == x && !mem_wait);
        er[x] = (mdl_pend && mdl_owner == x) ? mem_rd : '0;
      end
      chk("wait0", wait0, e_wait[0]);
      chk("wait1", wait1, e_wait[1]);
      chk("rdata0", rdata0, er[0]);
      chk("rdata1", rdata1, er[1]);
      chk("mem_sel", m_sel, eff);
      chk("mem_rd",  m_rd,  eff ? (rd[g] && !wr[g]) : 1'b0);
      chk("mem_wr",  m_wr,  eff ? wr[g] : 1'b0);
      chk("mem_addr", m_addr, eff ? addr[g] : '0);
      chk("mem_wd",  m_wd,  eff ? wd[g] : '0);
      chk("mem_be",  m_be,  eff ? be[g] : '0);
      if (acc) begin
        mdl_pend  = rd[g] && !wr[g];
        mdl_owner = g;
        mdl_last  = g;
        mdl_hold  = -1;
      end else begin
        mdl_pend  = 1'b0;
        mdl_hold  = (eff && mem_wait) ? g : -1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int x);
    sel[x] = 1'b0; rd[x] = 1'b0; wr[x] = 1'b0;
    addr[x] = '0; wd[x] = '0; be[x] = '0;
  endtask

  task automatic req(input int x, input bit r, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [BW-1:0] b);
    sel[x] = 1'b1; rd[x] = r; wr[x] = w; addr[x] = a; wd[x] = d; be[x] = b;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int nwait;
    int k;
    rst_n = 1'b0;
    idle(0); idle(1);
    mem_rd = '0; mem_wait = 1'b0;
    #3;
    chk("rst_rdata0", rdata0, '0);
    chk("rst_rdata1", rdata1, '0);
    chk("rst_memsel", m_sel, 1'b0);
    #9 rst_n = 1'b1;
    chk_en = 1'b1;

    // AV0 read alone, zero-wait, data next clock
    step();
    req(0, 1, 0, 24'h10, '0, 4'hF);
    sample();
    chk("t2_wait0", wait0, 1'b0);
    chk("t2_addr", m_addr, 24'h10);
    chk("t2_memrd", m_rd, 1'b1);
    step();
    idle(0);
    mem_rd = 32'hff010113;
    sample();
    chk("t2_rdata0", rdata0, 32'hff010113);
    chk("t2_rdata1", rdata1, '0);

    // Reset mid-way through the read-data cycle
    step();
    req(0, 1, 0, 24'h3, '0, 4'hF);
    mem_rd = 32'h12345678;
    step();
    idle(0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rdata0", rdata0, '0);
    chk("t1_memsel", m_sel, 1'b0);
    chk("t1_wait0", wait0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Both read continuously from reset
    step();
    req(0, 1, 0, 24'h100, '0, 4'hF);
    req(1, 1, 0, 24'h200, '0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      sample();
`ifdef AV_MEM_ARB_FIXED_PRIO_EN
      chk("t6_wait0", wait0, 1'b0);
      chk("t6_wait1", wait1, 1'b1);
      chk("t6_addr", m_addr, 24'h100);
`else
      chk("t3_wait0", wait0, (i % 2) == 1);
      chk("t3_wait1", wait1, (i % 2) == 0);
      chk("t3_addr", m_addr, (i % 2) ? 24'h200 : 24'h100);
`endif
    end
    step();
    idle(0); idle(1);

`ifndef AV_MEM_ARB_FIXED_PRIO_EN
    // AV0 wins first so AV1 wins the tie, then AV1 stalls 3 cycles
    step();
    req(0, 1, 0, 24'h40, '0, 4'hF);
    step();
    req(0, 1, 0, 24'h41, '0, 4'hF);
    req(1, 1, 0, 24'h51, '0, 4'hF);
    mem_wait = 1'b1;
    nwait = 0;
    for (int j = 0; j < 5; j++) begin
      sample();
      if (wait0) nwait++;
      chk("t4_addr", m_addr, (j < 4) ? 24'h51 : 24'h41);
      if (j == 3) chk("t4_wait1_acc", wait1, 1'b0);
      if (j == 4) chk("t4_wait0_gnt", wait0, 1'b0);
      if (j < 4) begin
        step();
        mem_wait = (j < 2);
        if (j == 3) idle(1);
      end
    end
    chk("t4_av0_waits", nwait, 4);
    step();
    idle(0); idle(1);
    mem_wait = 1'b0;
`endif

    // AV1 write with AV0 idle
    step();
    req(1, 0, 1, 24'h5, 32'hDEADBEEF, 4'b0011);
    sample();
    chk("t5_sel", m_sel, 1'b1);
    chk("t5_wr", m_wr, 1'b1);
    chk("t5_rd", m_rd, 1'b0);
    chk("t5_addr", m_addr, 24'h5);
    chk("t5_wd", m_wd, 32'hDEADBEEF);
    chk("t5_be", m_be, 4'b0011);
    chk("t5_wait1", wait1, 1'b0);
    step();
    idle(1);
    mem_rd = 32'hA5A5A5A5;
    sample();
    chk("t5_rdata0", rdata0, '0);
    chk("t5_rdata1", rdata1, '0);

    // Random traffic; masters hold while the model says they wait
    repeat (600) begin
      step();
      for (int x = 0; x < 2; x++) begin
        if (e_wait[x]) begin
          if ($urandom_range(0, 49) == 0) begin
            rd[x] = 1'b0; wr[x] = 1'b0;
          end
        end else if ($urandom_range(0, 9) < 6) begin
          k = $urandom_range(0, 3);
          req(x, k != 1, (k % 2) == 1, AW'($urandom), $urandom, BW'($urandom));
          sel[x] = ($urandom_range(0, 9) != 0);
        end else begin
          idle(x);
          sel[x] = $urandom_range(0, 1);
        end
      end
      mem_wait = ($urandom_range(0, 9) < 3);
      mem_rd = $urandom;
    end

    step();
    idle(0); idle(1);
    mem_wait = 1'b0;
    sample();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
